reg_bank_scheduler: RTL
=======================

Name: reg_bank_scheduler

Overview:
Sequences all accesses to the sprite register bank and its attached collision unit. It shares the bank between a host write requester and a once-per-frame collision scan. It drives the bank's register select, data, write strobe and collision enable; it confirms writes via the bank's success flag and latches the 30 collision flags at the end of each scan. It sits between the instruction decoder and the register bank, on the same clock.

Parameters:
COLL_CYCLES, 32, cycles collision enable is held high per scan (range 1..255)
WR_TIMEOUT, 8, cycles to wait for success after a write strobe before flagging error (range 1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_req  in  1  host write request; held with wr_reg/wr_data until wr_ready sampled high
wr_reg  in  5  target register index
wr_data  in  32  data word to write
wr_ready  out  1  high in IDLE when no scan is pending; request accepted on wr_req&wr_ready
wr_done  out  1  1-cycle pulse: write confirmed by success
wr_err  out  1  1-cycle pulse: write timed out
frame_start  in  1  1-cycle pulse: start-of-frame, requests a collision scan
rf_n_reg  out  5  register select to bank
rf_data  out  32  write data to bank
rf_written  out  1  write strobe to bank
rf_success  in  1  write-success flag from bank
rf_collision_en  out  1  collision unit enable
rf_flags  in  30  collision flags from collision unit
coll_flags  out  30  flags latched at end of last scan
coll_valid  out  1  1-cycle pulse when coll_flags updates
overrun  out  1  sticky; set when frame_start arrives while a scan is pending or active; cleared only by reset
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: all state changes on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; every output 0 except wr_ready=1; coll_flags=0; pending=0; overrun=0; counters=0. Reset mid-operation aborts immediately, with no wr_done, wr_err or coll_valid pulse.
- pending flag: set on frame_start; cleared on entry to SCAN.
- overrun: set by frame_start while pending=1 or state=SCAN.
- wr_ready = (state==IDLE) & ~pending & ~frame_start.
- FSM states and transitions:
  - IDLE:
    - pending=1 -> SCAN (the scan has priority over a write).
    - Otherwise, wr_req&wr_ready -> WRITE; latch wr_reg/wr_data into rf_n_reg/rf_data.
  - WRITE (1 cycle):
    - rf_written=1; rf_n_reg/rf_data hold the latched values; go to CONFIRM; clear the timeout counter.
  - CONFIRM:
    - rf_written=0; rf_n_reg/rf_data remain held.
    - rf_success=1 -> pulse wr_done; go to IDLE.
    - Otherwise the counter increments; when the counter reaches WR_TIMEOUT -> pulse wr_err; go to IDLE.
    - If rf_success and the timeout coincide, success wins (wr_done only).
  - SCAN:
    - rf_collision_en=1 for exactly COLL_CYCLES consecutive cycles; then go to LATCH.
  - LATCH (1 cycle):
    - rf_collision_en=0; coll_flags<=rf_flags; pulse coll_valid; go to IDLE.
- Write latency: acceptance edge -> rf_written high the next cycle. wr_done follows at the earliest 2 cycles after acceptance; wr_err exactly WR_TIMEOUT+2 cycles after acceptance.
- A frame_start during WRITE/CONFIRM is deferred. The write completes first, then IDLE -> SCAN on the next edge.
- A frame_start in the same cycle as wr_req in IDLE: the write is not accepted (wr_ready=0); the scan runs first.
- rf_written is never high in the same cycle as rf_collision_en.
- rf_n_reg/rf_data hold their last written values outside writes.
- coll_flags hold between scans.
- Counters are 8-bit and saturate-free within the parameter ranges.

Test Plan:
- Reset -> wr_ready=1, busy=0, all rf_* outputs =0, coll_flags=0. Then wr_req with wr_reg=5, wr_data=0x00ABCDEF, and rf_success returned 1 cycle after the strobe -> rf_written 1 cycle with rf_n_reg=5, rf_data=0x00ABCDEF; wr_done pulse; return to IDLE.
- Write with rf_success held 0, WR_TIMEOUT=8 -> wr_err pulse exactly 10 cycles after acceptance; no wr_done; wr_ready returns high.
- frame_start with rf_flags=30'h0000_0005 and COLL_CYCLES=32 -> rf_collision_en high for exactly 32 cycles; coll_flags=0x5 with one coll_valid pulse; wr_ready low throughout.
- frame_start during CONFIRM -> write completes with wr_done; the scan starts on the cycle after return to IDLE; rf_written and rf_collision_en never overlap.
- frame_start and wr_req in the same cycle -> scan runs first; the write is accepted after LATCH with its data unchanged. A second frame_start during SCAN -> overrun=1 and stays 1 until reset.
- Assert reset during SCAN, cycle 10 -> rf_collision_en=0 on the next edge; no coll_valid; coll_flags=0; state=IDLE.

Source files
------------

// File: rtl/reg_bank_scheduler_if.sv
// Host-write, frame and register-bank signals of the sprite register bank scheduler.
// The scheduler takes the slave view; the host/bank side takes the master view.
interface reg_bank_scheduler_if;
    // Host write requester
    logic        wr_req;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        wr_done;
    logic        wr_err;

    // Frame timing
    logic        frame_start;

    // Register bank and collision unit
    logic [4:0]  rf_n_reg;
    logic [31:0] rf_data;
    logic        rf_written;
    logic        rf_success;
    logic        rf_collision_en;
    logic [29:0] rf_flags;

    // Status
    logic [29:0] coll_flags;
    logic        coll_valid;
    logic        overrun;
    logic        busy;

    modport slave (
        input  wr_req, wr_reg, wr_data, frame_start, rf_success, rf_flags,
        output wr_ready, wr_done, wr_err, rf_n_reg, rf_data, rf_written,
               rf_collision_en, coll_flags, coll_valid, overrun, busy
    );

    modport master (
        output wr_req, wr_reg, wr_data, frame_start, rf_success, rf_flags,
        input  wr_ready, wr_done, wr_err, rf_n_reg, rf_data, rf_written,
               rf_collision_en, coll_flags, coll_valid, overrun, busy
    );
endinterface

// File: rtl/reg_bank_scheduler.sv
// Shares the sprite register bank between host writes and a once-per-frame
// collision scan; confirms writes via rf_success and latches the collision flags.
module reg_bank_scheduler #(
    parameter int COLL_CYCLES = 32,
    parameter int WR_TIMEOUT  = 8
) (
    input logic                 clk,
    input logic                 reset,
    reg_bank_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CONFIRM,
        SCAN,
        LATCH
    } state_e;

    localparam logic [7:0] COLL_LAST = 8'(COLL_CYCLES - 1);
    localparam logic [7:0] WR_LIMIT  = 8'(WR_TIMEOUT);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic [4:0]  n_reg_q;
    logic [31:0] data_q;
    logic        written_q;
    logic        coll_en_q;
    logic        done_q;
    logic        err_q;
    logic        coll_valid_q;
    logic [29:0] coll_flags_q;
    logic        ready;

    // A frame_start in the same cycle blocks acceptance so the scan always goes first.
    assign ready = (state_q == IDLE) && !pending_q && !bus.frame_start;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pending_d = pending_q;
        overrun_d = overrun_q;
        if ((state_q == IDLE) && pending_q) begin
            pending_d = 1'b0;
        end
        if (bus.frame_start) begin
            pending_d = 1'b1;
            if (pending_q || (state_q == SCAN)) begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: all registers here are control state and get an explicit reset value; there is no storage array.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            n_reg_q      <= '0;
            data_q       <= '0;
            written_q    <= 1'b0;
            coll_en_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            coll_valid_q <= 1'b0;
            coll_flags_q <= '0;
        end else begin
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            coll_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q   <= SCAN;
                        coll_en_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (bus.wr_req && ready) begin
                        state_q   <= WRITE;
                        n_reg_q   <= bus.wr_reg;
                        data_q    <= bus.wr_data;
                        written_q <= 1'b1;
                    end
                end

                WRITE: begin
                    state_q   <= CONFIRM;
                    written_q <= 1'b0;
                    cnt_q     <= '0;
                end

                // Success is checked before the timeout so a coincident success still confirms.
                CONFIRM: begin
                    if (bus.rf_success) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (cnt_q == WR_LIMIT) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                SCAN: begin
                    if (cnt_q == COLL_LAST) begin
                        state_q   <= LATCH;
                        coll_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                LATCH: begin
                    state_q      <= IDLE;
                    coll_flags_q <= bus.rf_flags;
                    coll_valid_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready        = ready;
    assign bus.wr_done         = done_q;
    assign bus.wr_err          = err_q;
    assign bus.rf_n_reg        = n_reg_q;
    assign bus.rf_data         = data_q;
    assign bus.rf_written      = written_q;
    assign bus.rf_collision_en = coll_en_q;
    assign bus.coll_flags      = coll_flags_q;
    assign bus.coll_valid      = coll_valid_q;
    assign bus.overrun         = overrun_q;
    assign bus.busy            = (state_q != IDLE);

endmodule
